// File: rtl/hamming_pkg.sv
// Shared Hamming helpers for the encoder and decoder: power-of-two test,
// parity-width legality/sizing and the data-index to codeword-position map.
package hamming_pkg;

    function automatic bit is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Legal when the R-bit syndrome can name every position plus "no error".
    function automatic bit hamming_legal(input int n, input int r);
        return (r > 0) && (r < 31) && ((1 << r) >= n + r + 1);
    endfunction

    function automatic int min_parity(input int n);
        int r;
        r = 1;
        while ((1 << r) < n + r + 1) r++;
        return r;
    endfunction

    // Codeword position of data bit k (k starts at 1): k-th non-power-of-two.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < 1024; p++) begin
            if (pos == 0 && !is_pow2(p)) begin
                cnt++;
                if (cnt == k) pos = p;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_decode_pipe_if.sv
// Valid/ready bus of the Hamming decoder: codeword in, decoded result out.
// slave = decoder side, master = channel/sink side.
interface hamming_decode_pipe_if #(
    parameter int N = 7,
    parameter int R = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [1:N+R]   en_stream;
    logic           out_valid;
    logic           out_ready;
    logic [1:N]     data;
    logic [R-1:0]   syndrome;
    logic           corrected;
    logic           uncorrectable;

    modport slave (
        input  in_valid, en_stream, out_ready,
        output in_ready, out_valid, data, syndrome,
        output corrected, uncorrectable
    );

    modport master (
        output in_valid, en_stream, out_ready,
        input  in_ready, out_valid, data, syndrome,
        input  corrected, uncorrectable
    );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational even-parity Hamming syndrome generator.
// i_cw: codeword, bit 1 = position 1; o_syn: R-bit syndrome.
module hamming_syndrome #(
    parameter int N = 7,
    parameter int R = 4
) (
    input  logic [1:N+R]  i_cw,
    output logic [R-1:0]  o_syn
);
    always_comb begin
        o_syn = '0;
        for (int i = 0; i < R; i++) begin
            for (int j = 1; j <= N + R; j++) begin
                if ((j & (1 << i)) != 0) o_syn[i] = o_syn[i] ^ i_cw[j];
            end
        end
    end
endmodule

// File: rtl/hamming_decode_pipe.sv
// Two-stage SEC Hamming decoder with valid/ready flow control and
// saturating error counters.
// Ports: clk, rst_n (async low), bus (slave: codeword in, result out),
// clr_count (sync clear), corr_count / uncorr_count (saturating).
module hamming_decode_pipe
    import hamming_pkg::*;
#(
    parameter int N     = 7,
    parameter int R     = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hamming_decode_pipe_if.slave bus,
    input  logic                 clr_count,
    output logic [CNT_W-1:0]     corr_count,
    output logic [CNT_W-1:0]     uncorr_count
);
    localparam int              NR   = N + R;
    localparam logic [R:0]      LIM  = (R+1)'(NR);
    localparam logic [CNT_W-1:0] CMAX = '1;

    if (!hamming_legal(N, R)) begin : g_illegal
        $error("hamming_decode_pipe: 2**R must be >= N+R+1");
    end

    logic             r_s1_valid;
    logic [1:NR]      r_cw;
    logic [R-1:0]     r_syn;
    logic             r_s2_valid;
    logic [1:N]       r_data;
    logic [R-1:0]     r_syn2;
    logic             r_corr;
    logic             r_unc;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_unc_cnt;

    logic [R-1:0]     w_syn;
    logic             w_s2_load;
    logic             w_out_xfer;
    logic [R:0]       w_syn_ext;
    logic             w_fix;
    logic             w_unc;
    logic [1:NR]      w_fixed;
    logic [1:N]       w_data;

    hamming_syndrome #(.N(N), .R(R)) u_syn (
        .i_cw  (bus.en_stream),
        .o_syn (w_syn)
    );

    // in_ready looks through a draining S2 so streaming has no bubble.
    assign w_s2_load     = !r_s2_valid || bus.out_ready;
    assign bus.in_ready  = !r_s1_valid || w_s2_load;
    assign w_out_xfer    = r_s2_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_cw       <= '0;
            r_syn      <= '0;
        end else if (bus.in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_cw  <= bus.en_stream;
                r_syn <= w_syn;
            end
        end
    end

    // Widened by one bit so the range test against N+R cannot wrap.
    assign w_syn_ext = {1'b0, r_syn};
    assign w_fix     = (w_syn_ext != '0) && (w_syn_ext <= LIM);
    assign w_unc     = (w_syn_ext > LIM);

    always_comb begin
        w_fixed = r_cw;
        for (int j = 1; j <= NR; j++) begin
            if (w_fix && (w_syn_ext == (R+1)'(j))) w_fixed[j] = ~r_cw[j];
        end
    end

    for (genvar k = 1; k <= N; k++) begin : g_ext
        localparam int P = data_pos(k);
        assign w_data[k] = w_fixed[P];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_data     <= '0;
            r_syn2     <= '0;
            r_corr     <= 1'b0;
            r_unc      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data <= w_data;
                r_syn2 <= r_syn;
                r_corr <= w_fix;
                r_unc  <= w_unc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
        end else if (clr_count) begin
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
        end else if (w_out_xfer) begin
            if (r_corr && r_corr_cnt != CMAX)
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            if (r_unc && r_unc_cnt != CMAX)
                r_unc_cnt <= r_unc_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid     = r_s2_valid;
    assign bus.data          = r_data;
    assign bus.syndrome      = r_syn2;
    assign bus.corrected     = r_corr;
    assign bus.uncorrectable = r_unc;
    assign corr_count        = r_corr_cnt;
    assign uncorr_count      = r_unc_cnt;

endmodule

// File: doc/hamming_decode_pipe.md
Name: hamming_decode_pipe

Overview:
- Pipelined single-error-correcting Hamming decoder. It is the receive-side counterpart of the team's even-parity Hamming encoder.
- Accepts an (N+R)-bit codeword with even-parity bits at power-of-two positions 1, 2, 4, …; data occupies the remaining positions in ascending order.
- Computes the syndrome, corrects one flipped bit, extracts the N data bits and keeps saturating error statistics.
- Sits between the error-injection channel and the data sink, with valid/ready handshakes on both sides.

Parameters:
- N, 7: data bits per codeword.
- R, 4: parity bits. Legal only if 2^R >= N+R+1; otherwise elaboration fails.
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  en_stream is valid.
- in_ready  out  1  decoder can accept a codeword.
- en_stream  in  [1:N+R]  codeword, bit 1 = position 1.
- out_valid  out  1  decoded result is valid.
- out_ready  in  1  sink accepts the result.
- data  out  [1:N]  corrected data. data[1] comes from the first non-power-of-two position (3).
- syndrome  out  R  raw syndrome of the delivered word.
- corrected  out  1  syndrome is in 1..N+R and the bit at that position was flipped.
- uncorrectable  out  1  syndrome > N+R; data is delivered uncorrected.
- clr_count  in  1  synchronous clear of both counters.
- corr_count  out  CNT_W  saturating count of delivered words with corrected=1.
- uncorr_count  out  CNT_W  saturating count of delivered words with uncorrectable=1.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; both stage-valid flags=0.
  - data=0, syndrome=0, corrected=0, uncorrectable=0, corr_count=0, uncorr_count=0.
  - in_ready=1 once the design is out of reset.
- Reset asserted mid-operation discards all in-flight words; no partial output after release.
- Handshakes:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - Output payload is held stable while out_valid && !out_ready.
- Two-stage pipeline, latency 2 cycles from input transfer to out_valid with out_ready held high; throughput 1 word/cycle.
- Stage 1 (S1): registers the codeword and syndrome.
  - Syndrome bit i = XOR of en_stream[j] over all j in 1..N+R where (j & 2^i) != 0.
- Stage 2 (S2): correction and extraction.
  - Syndrome 0: no flip; corrected=0, uncorrectable=0.
  - Syndrome 1..N+R: invert that position. corrected=1 even if the position is a parity bit; data is then unchanged.
  - Syndrome > N+R: no flip; uncorrectable=1.
  - Data extraction: walk positions 1..N+R ascending, skip powers of two, assign to data[1..N] in order.
- Stall rules:
  - S2 loads when !S2_valid || out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !S1_valid || S2 loads this cycle. This is combinational from out_ready; no bubble when streaming.
- Double errors are not detected generally. Aliased syndromes within 1..N+R miscorrect by design (SEC only, no DED).
- Counters:
  - Each increments by 1 on an output transfer when its flag is set, saturating at 2^CNT_W-1.
  - clr_count forces both to 0 next cycle; clear wins over a simultaneous increment.
- All arithmetic is unsigned. Syndrome comparison against N+R uses R+1 bits so it cannot wrap.

Decomposition:
- Shared package hamming_pkg holds:
  - is_pow2(position) function.
  - syndrome width / legality-check constant function.
  - data-position-map function (k-th data index → codeword position).
  - The encoder reuses the same package.
- One sub-module, hamming_syndrome: combinational syndrome generator with the same N and R parameters. It is instantiated in S1 and is also usable by the encoder's self-check.

Test Plan:
- Clean word: data 1010101 encodes to 11110100101 (pos1..11). Send with out_ready=1 → after 2 cycles: data=1010101, syndrome=0, corrected=0, uncorrectable=0, counters unchanged.
- Data error: 11110000101 (pos 6 flipped) → syndrome=6, corrected=1, data=1010101, corr_count=1.
- Parity error: 11110101101 (pos 8 flipped) → syndrome=8, corrected=1, data=1010101.
- Uncorrectable: 11100101101 (pos 4 and 8 flipped) → syndrome=12, uncorrectable=1, data=1010101 unflipped, uncorr_count=1.
- Backpressure: stream 4 words with out_ready low for cycles 2–5.
  - in_ready drops after 2 words are held.
  - Outputs stay stable, with no loss or duplication, in order.
- Reset and counters:
  - Assert rst_n=0 with both stages full → out_valid=0 immediately, counters=0.
  - Force corr_count to saturate with CNT_W=2 → it holds at 3.
  - clr_count asserted with an increment → counter is 0.
